// File: rtl/fp_sum_sequencer.sv
// Operand feeder for the multi-cycle FP adder: folds each in_last-terminated group into one total.
// Optional FP_SUM_ZERO_SKIP_EN: a non-first +/-0 operand is counted but issues no add.
module fp_sum_sequencer #(
  parameter int expWidth      = 7,
  parameter int mantissaWidth = 24,
  parameter int CNT_WIDTH     = 8,
  localparam int W            = expWidth + mantissaWidth + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [W-1:0]         in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [W-1:0]         add_a,
  output logic [W-1:0]         add_b,
  output logic                 add_start,
  input  logic                 add_ready,
  input  logic [W-1:0]         add_s,
  output logic [W-1:0]         sum,
  output logic                 sum_valid,
  input  logic                 sum_ack,
  output logic [CNT_WIDTH-1:0] count
);

  typedef enum logic [1:0] {
    ACCEPT,
    ISSUE,
    ADD_WAIT,
    OUTPUT
  } state_t;

  state_t               state_q;
  logic                 first_q;
  logic                 last_q;
  logic                 addReadyPrev_q;
  logic [W-1:0]         acc_q;
  logic [W-1:0]         opnd_q;
  logic [W-1:0]         addA_q;
  logic [W-1:0]         addB_q;
  logic [W-1:0]         sum_q;
  logic                 addStart_q;
  logic                 sumValid_q;
  logic                 inReady_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] countInc_d;
  logic                 isZero_d;

  assign countInc_d = (count_q == {CNT_WIDTH{1'b1}}) ? count_q : count_q + 1'b1;
  assign isZero_d   = (in_data[W-2:0] == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ACCEPT;
      first_q        <= 1'b1;
      last_q         <= 1'b0;
      addReadyPrev_q <= 1'b0;
      acc_q          <= '0;
      opnd_q         <= '0;
      addA_q         <= '0;
      addB_q         <= '0;
      sum_q          <= '0;
      addStart_q     <= 1'b0;
      sumValid_q     <= 1'b0;
      inReady_q      <= 1'b1;
      count_q        <= '0;
    end else begin
      addStart_q <= 1'b0;
      unique case (state_q)
        ACCEPT: begin
          if (in_valid) begin
            if (first_q) begin
              acc_q   <= in_data;
              count_q <= {{(CNT_WIDTH-1){1'b0}}, 1'b1};
              first_q <= 1'b0;
              if (in_last) begin
                sum_q      <= in_data;
                sumValid_q <= 1'b1;
                inReady_q  <= 1'b0;
                state_q    <= OUTPUT;
              end
            end else begin
              count_q <= countInc_d;
`ifdef FP_SUM_ZERO_SKIP_EN
              if (isZero_d) begin
                if (in_last) begin
                  sum_q      <= acc_q;
                  sumValid_q <= 1'b1;
                  inReady_q  <= 1'b0;
                  state_q    <= OUTPUT;
                end
              end else begin
                opnd_q    <= in_data;
                last_q    <= in_last;
                inReady_q <= 1'b0;
                state_q   <= ISSUE;
              end
`else
              opnd_q    <= in_data;
              last_q    <= in_last;
              inReady_q <= 1'b0;
              state_q   <= ISSUE;
`endif
            end
          end
        end
        ISSUE: begin
          addA_q         <= acc_q;
          addB_q         <= opnd_q;
          addStart_q     <= 1'b1;
          addReadyPrev_q <= 1'b0;
          state_q        <= ADD_WAIT;
        end
        // Completion is the rising edge of add_ready, so a level left high cannot retrigger.
        ADD_WAIT: begin
          addReadyPrev_q <= add_ready;
          if (add_ready && !addReadyPrev_q) begin
            acc_q <= add_s;
            if (last_q) begin
              sum_q      <= add_s;
              sumValid_q <= 1'b1;
              state_q    <= OUTPUT;
            end else begin
              inReady_q <= 1'b1;
              state_q   <= ACCEPT;
            end
          end
        end
        OUTPUT: begin
          if (sum_ack) begin
            first_q    <= 1'b1;
            sumValid_q <= 1'b0;
            inReady_q  <= 1'b1;
            state_q    <= ACCEPT;
          end
        end
        default: state_q <= ACCEPT;
      endcase
    end
  end

`ifndef FP_SUM_ZERO_SKIP_EN
  logic unusedZero;
  assign unusedZero = isZero_d;
`endif

  assign in_ready  = inReady_q;
  assign add_a     = addA_q;
  assign add_b     = addB_q;
  assign add_start = addStart_q;
  assign sum       = sum_q;
  assign sum_valid = sumValid_q;
  assign count     = count_q;

endmodule

// File: tb/tb_fp_sum_sequencer.sv
// Directed bench for fp_sum_sequencer with a fixed-latency stub adder returning hand-computed sums.
module tb_fp_sum_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic         in_ready;
  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic         add_start;
  logic         add_ready;
  logic [W-1:0] add_s;
  logic [W-1:0] sum;
  logic         sum_valid;
  logic         sum_ack = 1'b0;
  logic [7:0]   count;

  int compared = 0;
  int mismatched = 0;

  fp_sum_sequencer dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .add_a(add_a), .add_b(add_b), .add_start(add_start),
    .add_ready(add_ready), .add_s(add_s),
    .sum(sum), .sum_valid(sum_valid), .sum_ack(sum_ack), .count(count)
  );

  always #5 clk = ~clk;

  // Hand-computed results for the operand pairs used below; unknown pairs pass a through.
  function automatic logic [W-1:0] fpAddModel(input logic [W-1:0] a, input logic [W-1:0] b);
    case ({a, b})
      {32'h3F000000, 32'h40000000}: return 32'h40800000;
      {32'h3F000000, 32'h3F000000}: return 32'h40000000;
      {32'h40000000, 32'h3F000000}: return 32'h40800000;
      {32'h40800000, 32'hBF000000}: return 32'h40000000;
      {32'h40000000, 32'h40000000}: return 32'h41000000;
      {32'h3F000000, 32'h00000000}: return 32'h3F000000;
      default:                      return a;
    endcase
  endfunction

  logic [W-1:0] pendA, pendB, lastA, lastB;
  logic [2:0]   delay;
  int           startCount = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      add_ready <= 1'b0;
      add_s     <= '0;
      delay     <= '0;
    end else begin
      add_ready <= 1'b0;
      if (add_start) begin
        pendA      <= add_a;
        pendB      <= add_b;
        lastA      <= add_a;
        lastB      <= add_b;
        startCount <= startCount + 1;
        delay      <= 3'd3;
      end else if (delay != 3'd0) begin
        delay <= delay - 3'd1;
        if (delay == 3'd1) begin
          add_ready <= 1'b1;
          add_s     <= fpAddModel(pendA, pendB);
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one operand and waits (bounded) for it to be taken.
  task automatic applyStimulus(input logic [W-1:0] data, input logic last);
    bit taken = 0;
    in_data  = data;
    in_last  = last;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !taken; i++) begin
      taken = in_ready;
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!taken) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitSum();
    for (int i = 0; i < 200 && !sum_valid; i++) tick();
    checkOutput("sum_valid_timeout", {31'd0, sum_valid}, 32'd1);
  endtask

  task automatic ackSum();
    sum_ack = 1'b1;
    tick();
    sum_ack = 1'b0;
  endtask

  int base;
  int expStarts;

  initial begin
    $display("[TB] start");
    #12;
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reset_sum_valid", {31'd0, sum_valid}, 32'd0);
    checkOutput("reset_sum", sum, 32'd0);
    checkOutput("reset_count", {24'd0, count}, 32'd0);
    checkOutput("reset_add_start", {31'd0, add_start}, 32'd0);
    reset = 1'b1;
    tick();

    // Single operand passes through untouched
    base = startCount;
    applyStimulus(32'h3F000000, 1'b1);
    waitSum();
    checkOutput("t1_sum", sum, 32'h3F000000);
    checkOutput("t1_count", {24'd0, count}, 32'd1);
    checkOutput("t1_starts", startCount - base, 32'd0);
    ackSum();

    base = startCount;
    applyStimulus(32'h3F000000, 1'b0);
    applyStimulus(32'h40000000, 1'b1);
    waitSum();
    checkOutput("t2_sum", sum, 32'h40800000);
    checkOutput("t2_count", {24'd0, count}, 32'd2);
    checkOutput("t2_starts", startCount - base, 32'd1);
    checkOutput("t2_add_a", lastA, 32'h3F000000);
    checkOutput("t2_add_b", lastB, 32'h40000000);
    ackSum();

    base = startCount;
    applyStimulus(32'h3F000000, 1'b0);
    applyStimulus(32'h3F000000, 1'b0);
    applyStimulus(32'h3F000000, 1'b0);
    applyStimulus(32'hBF000000, 1'b1);
    waitSum();
    checkOutput("t3_sum", sum, 32'h40000000);
    checkOutput("t3_count", {24'd0, count}, 32'd4);
    checkOutput("t3_starts", startCount - base, 32'd3);

    // Result held while consumer stalls and upstream keeps offering data
    in_data  = 32'h40000000;
    in_last  = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("t4_hold_sum", sum, 32'h40000000);
      checkOutput("t4_hold_valid", {31'd0, sum_valid}, 32'd1);
      checkOutput("t4_hold_ready", {31'd0, in_ready}, 32'd0);
    end
    sum_ack = 1'b1;
    tick();
    sum_ack = 1'b0;
    checkOutput("t4_ack_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("t4_ack_valid", {31'd0, sum_valid}, 32'd0);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    checkOutput("t4_next_valid", {31'd0, sum_valid}, 32'd1);
    checkOutput("t4_next_sum", sum, 32'h40000000);
    checkOutput("t4_next_count", {24'd0, count}, 32'd1);
    ackSum();

    // Reset in the middle of an add
    applyStimulus(32'h3F000000, 1'b0);
    applyStimulus(32'h40000000, 1'b1);
    tick();
    reset = 1'b0;
    #1;
    checkOutput("t5_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("t5_sum_valid", {31'd0, sum_valid}, 32'd0);
    checkOutput("t5_sum", sum, 32'd0);
    checkOutput("t5_count", {24'd0, count}, 32'd0);
    checkOutput("t5_add_start", {31'd0, add_start}, 32'd0);
    checkOutput("t5_add_a", add_a, 32'd0);
    checkOutput("t5_add_b", add_b, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    applyStimulus(32'h40000000, 1'b0);
    applyStimulus(32'h40000000, 1'b1);
    waitSum();
    checkOutput("t5_sum_after", sum, 32'h41000000);
    checkOutput("t5_count_after", {24'd0, count}, 32'd2);
    ackSum();

    // Zero operand in the middle of a group
`ifdef FP_SUM_ZERO_SKIP_EN
    expStarts = 1;
`else
    expStarts = 2;
`endif
    base = startCount;
    applyStimulus(32'h3F000000, 1'b0);
    applyStimulus(32'h00000000, 1'b0);
    applyStimulus(32'h40000000, 1'b1);
    waitSum();
    checkOutput("t6_sum", sum, 32'h40800000);
    checkOutput("t6_count", {24'd0, count}, 32'd3);
    checkOutput("t6_starts", startCount - base, expStarts);
    ackSum();

    // Count saturates at 255 while accumulation continues
    applyStimulus(32'h3F000000, 1'b0);
    for (int i = 0; i < 299; i++) applyStimulus(32'h00000000, 1'b0);
    applyStimulus(32'h00000000, 1'b1);
    waitSum();
    checkOutput("sat_count", {24'd0, count}, 32'd255);
    checkOutput("sat_sum", sum, 32'h3F000000);
    ackSum();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
